i2c_rx_shifter: RTL
===================

Name: i2c_rx_shifter

Overview:
- Slave-receiver front end of the I2C block; sits directly upstream of i2c_rxfifo on its write-clock side.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches the 7-bit address, deserialises data bytes and drives ACK/NACK.
- Pushes each received byte into the RX FIFO via the active-low write strobe, honouring the FIFO full flag.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for scl_i/sda_i (min 2).
- DATA_WIDTH, 8, byte width; fixed at 8, present for the package constant only.

Ports:
- clk  in  1  system clock; same clock as FIFO wr_clk.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  block enable; 0 forces IDLE, releases the bus, no FIFO writes.
- own_addr  in  7  slave address.
- scl_i  in  1  raw SCL pad input (asynchronous).
- sda_i  in  1  raw SDA pad input (asynchronous).
- sda_oe  out  1  1 = pull SDA low (ACK).
- wr_n  out  1  FIFO write strobe, active-low, one clk wide.
- di  out  8  FIFO write data.
- full  in  1  FIFO full flag.
- busy  out  1  addressed transaction in progress.
- ovf  out  1  sticky: byte dropped because FIFO was full; cleared by rst, or by START while en=1.
- stop_det  out  1  one-clk pulse on STOP detection.

Behaviour:
- Reset values: sda_oe=0, wr_n=1, di=0, busy=0, ovf=0, stop_det=0; state=IDLE; bit_cnt=0; synchroniser and edge flops reset to 1 (idle bus).
- Input conditioning: SYNC_STAGES flops, then one history flop per line.
  - scl_rise / scl_fall / sda_rise / sda_fall are single-clk pulses.
  - Pad-to-event latency is SYNC_STAGES+1 clk.
- Bus events, evaluated on synchronised values:
  - START = sda_fall while scl high.
  - STOP = sda_rise while scl high.
  - START and STOP take priority over bit sampling in the same clk.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - Any state, START (en=1): go to ADDR, bit_cnt=0, sda_oe=0.
  - Any state, STOP: go to IDLE, sda_oe=0, pulse stop_det.
  - ADDR: each scl_rise shifts SDA in MSB-first and increments bit_cnt.
  - ADDR, 8th scl_rise: if shreg[7:1]==own_addr and R/W bit=0, go to ADDR_ACK; otherwise go to IGNORE. Read-direction addressing is not supported and is NACKed.
  - ADDR_ACK: on the next scl_fall set sda_oe=1. On the following scl_fall clear sda_oe, bit_cnt=0, go to DATA.
  - DATA: shifts as in ADDR. On the 8th scl_rise, di<=shreg byte.
    - If full=0 in that clk: wr_n=0 for exactly the next clk, and the byte will be ACKed.
    - If full=1: no write, ovf<=1, byte will be NACKed.
    - Then go to DATA_ACK.
  - DATA_ACK: on scl_fall set sda_oe = ack decision (1 for ACK, 0 for NACK). On the next scl_fall clear sda_oe, bit_cnt=0. Go to DATA if ACKed, IGNORE if NACKed.
  - IGNORE: sda_oe=0, only START/STOP are observed.
- busy=1 in ADDR_ACK, DATA, DATA_ACK; 0 otherwise.
- sda_oe is never asserted outside the ACK slot.
- en=0: synchronous return to IDLE next clk; sda_oe=0, wr_n=1.
- wr_n low never exceeds 1 clk and at most one write occurs per byte.
- full is sampled only in the write clk.
- Mid-byte START/STOP discards the partial byte; no write occurs.
- rst mid-transfer returns all outputs to their reset values in the next clk. The bus is released immediately after that clk.

Decomposition:
- Package i2c_pkg:
  - state encoding constants (3-bit) for the six FSM states;
  - I2C_BYTE_W=8;
  - I2C_ADDR_W=7;
  - ACK/NACK level constants.
- Sub-module i2c_sync_edge:
  - parameterised SYNC_STAGES synchroniser plus history flop;
  - outputs level, rise and fall pulses;
  - instantiated twice, once for SCL and once for SDA.

Test Plan:
- Write to own_addr=7'h50 (byte 8'hA0), data 8'h3C, then STOP → ACK driven in both ACK slots; one wr_n pulse with di=8'h3C; stop_det pulse; busy returns to 0.
- Address 8'hA2 (7'h51) to own_addr 7'h50 → sda_oe stays 0 throughout; no wr_n; FSM reaches IGNORE; busy=0.
- Address 8'hA1 (read to 7'h50) → NACK, IGNORE, no writes.
- full=1 during the 2nd of 3 data bytes (8'h11, 8'h22, 8'h33) → 8'h11 written and ACKed; 8'h22 NACKed and not written; ovf=1; 8'h33 ignored; next START clears ovf.
- Repeated START after 4 bits of a data byte, then address 8'hA0 and data 8'h5A → partial byte dropped; only 8'h5A written.
- rst asserted while sda_oe=1 in an ACK slot → next clk sda_oe=0, wr_n=1, busy=0, state IDLE. en=0 mid-byte gives the same result.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_pkg
//  Purpose  : Shared constants and types for the I2C slave receive path.
//             Holds the receiver FSM state encoding, the byte/address widths
//             and the SDA drive levels used in the acknowledge slot.
//  Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int I2C_BYTE_W = 8;
    localparam int I2C_ADDR_W = 7;

    // R/W bit value for a master write (the only direction this slave accepts)
    localparam logic I2C_WRITE = 1'b0;

    // Open-drain enable values for the acknowledge slot:
    // 1 pulls SDA low (ACK), 0 leaves the line released (NACK).
    localparam logic SDA_OE_ACK  = 1'b1;
    localparam logic SDA_OE_NACK = 1'b0;

    // Receiver FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } i2c_state_e;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_sync_edge
//  Purpose  : Brings one asynchronous bus line into the clk domain through a
//             SYNC_STAGES-deep flop chain, keeps one history flop, and
//             derives single-cycle rise/fall pulses from the pair.
//  Ports    : clk, rst       - system clock, synchronous active-high reset
//             d_i            - raw asynchronous pad input
//             level_o        - synchronised line level
//             rise_o, fall_o - one-clk edge pulses on the synchronised level
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2   // minimum 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // All flops reset to 1 so an idle (pulled-up) bus produces no edge
    // when reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule : i2c_sync_edge
`default_nettype wire

// File: rtl/i2c_rx_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_rx_shifter
//  Purpose  : I2C slave-receiver front end. Oversamples SCL/SDA, detects
//             START/STOP, matches the 7-bit address (write direction only),
//             deserialises data bytes, drives ACK/NACK and pushes each byte
//             into the RX FIFO write port.
//  Ports    : clk, rst        - system clock (= FIFO wr_clk), sync reset
//             en              - block enable; 0 forces IDLE and releases SDA
//             own_addr        - 7-bit slave address
//             scl_i, sda_i    - raw asynchronous pad inputs
//             sda_oe          - 1 pulls SDA low (ACK)
//             wr_n, di, full  - FIFO write strobe (active low), data, full
//             busy            - addressed transaction in progress
//             ovf             - sticky: byte dropped because FIFO was full
//             stop_det        - one-clk pulse on STOP
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_rx_shifter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [I2C_ADDR_W-1:0] own_addr,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic                  wr_n,
    output logic [DATA_WIDTH-1:0] di,
    input  logic                  full,
    output logic                  busy,
    output logic                  ovf,
    output logic                  stop_det
);

    localparam logic [3:0] LAST_BIT = 4'd7;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
        .clk     (clk),
        .rst     (rst),
        .d_i     (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
        .clk     (clk),
        .rst     (rst),
        .d_i     (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    // SDA may only change while SCL is low; a change while SCL is high is
    // a bus condition rather than data.
    logic bus_start, bus_stop;
    assign bus_start = sda_fall & scl_lvl;
    assign bus_stop  = sda_rise & scl_lvl;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    i2c_state_e            state_q;
    logic [3:0]            bit_cnt_q;
    logic [I2C_BYTE_W-1:0] shreg_q;
    logic [I2C_BYTE_W-1:0] shreg_d;
    logic                  ack_phase_q;  // 0: waiting to open ACK slot, 1: waiting to close it
    logic                  ack_ok_q;     // last data byte was accepted
    logic                  sda_oe_q;
    logic                  wr_n_q;
    logic [DATA_WIDTH-1:0] di_q;
    logic                  ovf_q;
    logic                  stop_det_q;
    logic                  addr_hit;

    // Shift register value after the current SCL rise (MSB first)
    assign shreg_d  = {shreg_q[I2C_BYTE_W-2:0], sda_lvl};
    assign addr_hit = (shreg_d[I2C_BYTE_W-1:1] == own_addr) && (shreg_d[0] == I2C_WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            ack_phase_q <= 1'b0;
            ack_ok_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            wr_n_q      <= 1'b1;
            di_q        <= '0;
            ovf_q       <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            // Strobes default inactive so each lasts exactly one clk
            wr_n_q     <= 1'b1;
            stop_det_q <= 1'b0;

            if (!en) begin
                state_q     <= ST_IDLE;
                bit_cnt_q   <= '0;
                ack_phase_q <= 1'b0;
                sda_oe_q    <= 1'b0;
            end else if (bus_start) begin
                // Covers repeated START; any partial byte is abandoned
                state_q     <= ST_ADDR;
                bit_cnt_q   <= '0;
                ack_phase_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                ovf_q       <= 1'b0;
            end else if (bus_stop) begin
                state_q     <= ST_IDLE;
                bit_cnt_q   <= '0;
                ack_phase_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                stop_det_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg_q   <= shreg_d;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= addr_hit ? ST_ADDR_ACK : ST_IGNORE;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase_q) begin
                                sda_oe_q    <= SDA_OE_ACK;
                                ack_phase_q <= 1'b1;
                            end else begin
                                sda_oe_q    <= 1'b0;
                                ack_phase_q <= 1'b0;
                                bit_cnt_q   <= '0;
                                state_q     <= ST_DATA;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (scl_rise) begin
                            shreg_q   <= shreg_d;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == LAST_BIT) begin
                                di_q <= shreg_d;
                                // full is only looked at here, in the write clk
                                if (!full) begin
                                    wr_n_q   <= 1'b0;
                                    ack_ok_q <= 1'b1;
                                end else begin
                                    ovf_q    <= 1'b1;
                                    ack_ok_q <= 1'b0;
                                end
                                state_q <= ST_DATA_ACK;
                            end
                        end
                    end

                    ST_DATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase_q) begin
                                sda_oe_q    <= ack_ok_q ? SDA_OE_ACK : SDA_OE_NACK;
                                ack_phase_q <= 1'b1;
                            end else begin
                                sda_oe_q    <= 1'b0;
                                ack_phase_q <= 1'b0;
                                bit_cnt_q   <= '0;
                                state_q     <= ack_ok_q ? ST_DATA : ST_IGNORE;
                            end
                        end
                    end

                    ST_IGNORE: begin
                        sda_oe_q <= 1'b0;
                    end

                    default: begin
                        state_q  <= ST_IDLE;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign wr_n     = wr_n_q;
    assign di       = di_q;
    assign ovf      = ovf_q;
    assign stop_det = stop_det_q;
    assign busy     = (state_q == ST_ADDR_ACK) || (state_q == ST_DATA) || (state_q == ST_DATA_ACK);

endmodule : i2c_rx_shifter
`default_nettype wire
